// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the counter datapath and the seven-segment scan controller:
// scan control, digit load strobe/data, and the shared decoder/digit enables.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    i_enable;
  logic                    i_load;
  logic [3*NUM_DIGITS-1:0] i_digits;
  logic [2:0]              o_digit_code;
  logic [NUM_DIGITS-1:0]   o_digit_sel;
  logic                    o_frame_done;

  modport master (
    output i_enable, i_load, i_digits,
    input  o_digit_code, o_digit_sel, o_frame_done
  );

  modport slave (
    input  i_enable, i_load, i_digits,
    output o_digit_code, o_digit_sel, o_frame_done
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow loading and
// inter-digit blanking. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  seven_seg_scan_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW      = 3 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  localparam state_t FIRST_PHASE = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]           shadow_q, shadow_d;
  logic [DW-1:0]           pending_q, pending_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [2:0]              code_q, code_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    done_q, done_d;
  logic                    boundary;
  logic [2:0]              raw_code;

  // Sequencing and digit-buffer update. Dropping i_enable wins over the
  // frame boundary, so a disabled frame neither pulses nor swaps buffers.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    boundary    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_enable) begin
          state_d = FIRST_PHASE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BLANK: begin
        if (!bus.i_enable) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRIVE: begin
        if (!bus.i_enable) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == TICK_LAST) begin
          state_d = FIRST_PHASE;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (state_q == S_IDLE) begin
      if (bus.i_load) shadow_d = bus.i_digits;
    end else if (boundary) begin
      if (bus.i_load)       shadow_d = bus.i_digits;
      else if (pend_flag_q) shadow_d = pending_q;
      pend_flag_d = 1'b0;
    end else if (bus.i_load) begin
      pending_d   = bus.i_digits;
      pend_flag_d = 1'b1;
    end

    done_d = boundary;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;

  // lz_mask[k] is set when digit k and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (shadow_d[3*k +: 3] == 3'd0);
      lz_mask[k] = upper_zero;
    end
  end
`endif

  // Next-output decode from the next state, so outputs are registered with it.
  always_comb begin
    raw_code = 3'h7;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) raw_code = shadow_d[3*k +: 3];
    end

    sel_d  = '1;
    code_d = 3'h7;
    if (state_d == S_BLANK) begin
      code_d = raw_code;
    end else if (state_d == S_DRIVE) begin
      code_d = raw_code;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) begin
          sel_d[k] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
          if (lz_mask[k]) code_d = 3'h7;
`endif
        end
      end
    end
  end

  // NOTE: the digit buffers are reset too; they are a few flops and the display
  // must show a defined value if scanning starts before the first load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      pend_flag_q <= 1'b0;
      code_q      <= 3'h7;
      sel_q       <= '1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      code_q      <= code_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_digit_code = code_q;
  assign bus.o_digit_sel  = sel_q;
  assign bus.o_frame_done = done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: a time-based frame model is
// compared against the DUT every cycle, with literal checks pinning the model.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int TD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = BC + TD;
  localparam int FRAME = ND * SLOT;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [3:0] sel, input logic [2:0] code, input logic done);
    check(name, {24'd0, bus.o_digit_sel, bus.o_digit_code, bus.o_frame_done},
          {24'd0, sel, code, done});
  endtask

  // Model: while scanning, m_t counts cycles since the scan started; the frame
  // position follows directly from m_t by division.
  logic       m_run;
  int         m_t;
  logic       m_done;
  logic       m_pflag;
  logic [2:0] m_shadow [ND];
  logic [2:0] m_pend   [ND];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run   <= 1'b0;
      m_t     <= 0;
      m_done  <= 1'b0;
      m_pflag <= 1'b0;
      for (int k = 0; k < ND; k++) begin
        m_shadow[k] <= 3'd0;
        m_pend[k]   <= 3'd0;
      end
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (bus.i_load)
          for (int k = 0; k < ND; k++) m_shadow[k] <= bus.i_digits[3*k +: 3];
        if (bus.i_enable) begin
          m_run <= 1'b1;
          m_t   <= 0;
        end
      end else if (!bus.i_enable) begin
        m_run <= 1'b0;
        if (bus.i_load) begin
          for (int k = 0; k < ND; k++) m_pend[k] <= bus.i_digits[3*k +: 3];
          m_pflag <= 1'b1;
        end
      end else begin
        m_t <= m_t + 1;
        if (m_t % FRAME == FRAME - 1) begin
          m_done  <= 1'b1;
          m_pflag <= 1'b0;
          if (bus.i_load)
            for (int k = 0; k < ND; k++) m_shadow[k] <= bus.i_digits[3*k +: 3];
          else if (m_pflag)
            for (int k = 0; k < ND; k++) m_shadow[k] <= m_pend[k];
        end else if (bus.i_load) begin
          for (int k = 0; k < ND; k++) m_pend[k] <= bus.i_digits[3*k +: 3];
          m_pflag <= 1'b1;
        end
      end
    end
  end

  function automatic logic lz_blank(input int d);
    if (!LZ || d == 0) return 1'b0;
    for (int j = d; j < ND; j++) if (m_shadow[j] != 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e_sel;
    logic [2:0] e_code;
    int p, d, ph;
    e_sel  = '1;
    e_code = 3'h7;
    if (m_run) begin
      p      = m_t % FRAME;
      d      = p / SLOT;
      ph     = p % SLOT;
      e_code = m_shadow[d];
      if (ph >= BC) begin
        e_sel[d] = 1'b0;
        if (lz_blank(d)) e_code = 3'h7;
      end
    end
    check("scan", {24'd0, bus.o_digit_sel, bus.o_digit_code, bus.o_frame_done},
          {24'd0, e_sel, e_code, m_done});
  end

  task automatic run_frame(input string tag, input logic [11:0] digits,
                           input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [2:0] e3);
    @(negedge clk); bus.i_enable = 1'b0;
    @(negedge clk); bus.i_load = 1'b1; bus.i_digits = digits;
    @(negedge clk); bus.i_load = 1'b0; bus.i_enable = 1'b1;
    for (int r = 0; r <= 24; r++) begin
      @(negedge clk);
      case (r)
        2:  pin({tag, "_d0"}, 4'b1110, e0, 1'b0);
        8:  pin({tag, "_d1"}, 4'b1101, e1, 1'b0);
        14: pin({tag, "_d2"}, 4'b1011, e2, 1'b0);
        20: pin({tag, "_d3"}, 4'b0111, e3, 1'b0);
        24: pin({tag, "_wrap"}, 4'b1111, e0, 1'b1);
        default: ;
      endcase
    end
  endtask

  initial begin
    bus.i_enable = 1'b0;
    bus.i_load   = 1'b0;
    bus.i_digits = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pin("idle_after_reset", 4'b1111, 3'h7, 1'b0);

    // Load in IDLE, then scan.
    @(negedge clk); bus.i_load = 1'b1; bus.i_digits = {3'd5, 3'd4, 3'd3, 3'd2};
    @(negedge clk); bus.i_load = 1'b0; bus.i_enable = 1'b1;
    for (int c = 0; c <= 93; c++) begin
      @(negedge clk);
      case (c)
        0:  pin("f1_blank0", 4'b1111, 3'd2, 1'b0);
        2:  pin("f1_d0", 4'b1110, 3'd2, 1'b0);
        5:  pin("f1_d0_end", 4'b1110, 3'd2, 1'b0);
        8:  pin("f1_d1", 4'b1101, 3'd3, 1'b0);
        14: pin("f1_d2", 4'b1011, 3'd4, 1'b0);
        20: pin("f1_d3", 4'b0111, 3'd5, 1'b0);
        23: pin("f1_d3_end", 4'b0111, 3'd5, 1'b0);
        24: pin("f1_done", 4'b1111, 3'd2, 1'b1);
        32: begin bus.i_load = 1'b1; bus.i_digits = {3'd0, 3'd1, 3'd1, 3'd1}; end
        33: bus.i_load = 1'b0;
        38: pin("f2_d2_old", 4'b1011, 3'd4, 1'b0);
        44: pin("f2_d3_old", 4'b0111, 3'd5, 1'b0);
        48: pin("f3_done_new", 4'b1111, 3'd1, 1'b1);
        50: pin("f3_d0_new", 4'b1110, 3'd1, 1'b0);
        56: pin("f3_d1_new", 4'b1101, 3'd1, 1'b0);
        68: pin("f3_d3_new", 4'b0111, LZ ? 3'd7 : 3'd0, 1'b0);
        71: begin bus.i_load = 1'b1; bus.i_digits = {3'd5, 3'd4, 3'd3, 3'd6}; end
        72: begin pin("f4_edge_load", 4'b1111, 3'd6, 1'b1); bus.i_load = 1'b0; end
        74: pin("f4_d0", 4'b1110, 3'd6, 1'b0);
        80: pin("f4_d1", 4'b1101, 3'd3, 1'b0);
        86: pin("f4_d2", 4'b1011, 3'd4, 1'b0);
        87: bus.i_enable = 1'b0;
        88: pin("disable_off", 4'b1111, 3'h7, 1'b0);
        90: begin pin("still_idle", 4'b1111, 3'h7, 1'b0); bus.i_enable = 1'b1; end
        91: pin("restart_blank", 4'b1111, 3'd6, 1'b0);
        93: pin("restart_d0", 4'b1110, 3'd6, 1'b0);
        default: ;
      endcase
    end

    run_frame("raw", {3'd7, 3'd6, 3'd0, 3'd1}, 3'd1, 3'd0, 3'd6, 3'd7);
    run_frame("lz_a", {3'd0, 3'd0, 3'd1, 3'd0}, 3'd0, 3'd1,
              LZ ? 3'd7 : 3'd0, LZ ? 3'd7 : 3'd0);
    run_frame("lz_0", {3'd0, 3'd0, 3'd0, 3'd0}, 3'd0,
              LZ ? 3'd7 : 3'd0, LZ ? 3'd7 : 3'd0, LZ ? 3'd7 : 3'd0);

    // Asynchronous reset mid-scan takes effect without a clock edge.
    repeat (5) @(negedge clk);
    @(posedge clk); #2; rst = 1'b1; #1;
    pin("async_reset_now", 4'b1111, 3'h7, 1'b0);
    @(negedge clk); bus.i_enable = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);
    pin("hold_after_release", 4'b1111, 3'h7, 1'b0);

    // Randomized traffic: rare enable drops, loads, zero-heavy digits, resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.i_enable = ($urandom_range(0, 99) < 97);
      bus.i_load   = ($urandom_range(0, 9) == 0);
      bus.i_digits = 12'($urandom) >> (3 * $urandom_range(0, 3));
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
